serial_alu: RTL and testbench

- Parametrised, multi-cycle successor to the one-bit ALU slice.
- Computes a WIDTH-bit AND/OR/ADD/SUB/SLT result by iterating a SLICE-bit carry-lookahead slice over the operands, least-significant slice first, with a registered inter-slice carry.
- Sits between the register-read stage and writeback.
- Uses a valid/ready handshake on input and output, so it can share a datapath with other multi-cycle units.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/serial_alu_if.sv | 31 +++
 rtl/alu_slice.sv | 73 +++++++
 rtl/serial_alu.sv | 153 +++++++++++++++
 tb/tb_serial_alu.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg : op encodings, FSM states and helpers for serial_alu    |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b111;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // SLT compares by subtraction regardless of op[2].
  function automatic logic binv_eff(input logic [2:0] op);
    return op[2] | (op[1:0] == 2'b11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_alu_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_alu_if : operand/result valid-ready bundle for serial_alu |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
interface serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             cout;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, overflow, cout
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, overflow, cout
  );
endinterface
`default_nettype wire

// File: rtl/alu_slice.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_slice : combinational SLICE-bit AND/OR/ADD slice, lookahead  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module alu_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  input  logic             binv_i,
  input  logic [1:0]       opsel_i,
  output logic [SLICE-1:0] res_o,
  output logic             cout_o,
  output logic             c_msb_in_o,
  output logic             g_o,
  output logic             p_o
);

  logic [SLICE-1:0] w_bb;
  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_p;
  logic [SLICE:0]   w_c;
  logic [SLICE-1:0] w_sum;
  logic             w_cnext;
  logic             w_pall;
  logic             w_ggrp;

  assign w_bb = b_i ^ {SLICE{binv_i}};
  assign w_g  = a_i & w_bb;
  assign w_p  = a_i | w_bb;

  // Each carry is a flat sum of products over the lower bits, not a ripple.
  always_comb begin
    w_c     = '0;
    w_cnext = 1'b0;
    w_pall  = 1'b1;
    w_ggrp  = 1'b0;
    w_c[0]  = cin_i;
    for (int i = 0; i < SLICE; i++) begin
      w_cnext = 1'b0;
      w_pall  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        w_cnext = w_cnext | (w_g[j] & w_pall);
        w_pall  = w_pall & w_p[j];
      end
      if (i == SLICE - 1) begin
        w_ggrp = w_cnext;
      end
      w_c[i+1] = w_cnext | (w_pall & cin_i);
    end
  end

  assign w_sum = a_i ^ w_bb ^ w_c[SLICE-1:0];

  always_comb begin
    res_o = '0;
    case (opsel_i)
      2'b00:   res_o = w_g;
      2'b01:   res_o = w_p;
      2'b10:   res_o = w_sum;
      default: res_o = '0;
    endcase
  end

  assign cout_o     = w_c[SLICE];
  assign c_msb_in_o = w_c[SLICE-1];
  assign g_o        = w_ggrp;
  assign p_o        = &w_p;

endmodule
`default_nettype wire

// File: rtl/serial_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_alu : multi-cycle WIDTH-bit ALU, one SLICE per clock      |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_alu_if.slave bus
);

  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             binv_q;
  logic [1:0]       opsel_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [SLICE-1:0] w_slice_res;
  logic             w_slice_cout;
  logic             w_slice_cmsb;
  logic             w_slice_g;
  logic             w_slice_p;
  logic [WIDTH-1:0] w_full;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             ovf_d;
  logic             set_d;
  logic             last_d;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a_i        (a_q[SLICE-1:0]),
    .b_i        (b_q[SLICE-1:0]),
    .cin_i      (carry_q),
    .binv_i     (binv_q),
    .opsel_i    (opsel_q),
    .res_o      (w_slice_res),
    .cout_o     (w_slice_cout),
    .c_msb_in_o (w_slice_cmsb),
    .g_o        (w_slice_g),
    .p_o        (w_slice_p)
  );

  // Earlier slices collect here so the visible result only changes on the last slice.
  generate
    if (NS == 1) begin : g_single
      assign w_full = w_slice_res;
    end else begin : g_multi
      logic [WIDTH-SLICE-1:0] acc_q;
      assign w_full = {w_slice_res, acc_q};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_q <= '0;
        end else if (state_q == RUN) begin
          acc_q <= w_full[WIDTH-1:SLICE];
        end
      end
    end
  endgenerate

  assign carry_d = w_slice_g | (w_slice_p & carry_q);
  assign last_d  = (cnt_q == CW'(NS - 1));
  assign ovf_d   = w_slice_cmsb ^ w_slice_cout;
  assign set_d   = (a_q[SLICE-1] ^ b_q[SLICE-1] ^ binv_q ^ w_slice_cmsb) ^ ovf_d;

  always_comb begin
    result_d = w_full;
    if (opsel_q == 2'b11) begin
      result_d[0] = set_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      binv_q      <= 1'b0;
      opsel_q     <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            opsel_q    <= bus.op[1:0];
            binv_q     <= binv_eff(bus.op);
            carry_q    <= binv_eff(bus.op);
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            result_q    <= result_d;
            zero_q      <= (result_d == '0);
            ovf_q       <= (opsel_q == 2'b10) ? ovf_d : 1'b0;
            cout_q      <= (opsel_q == 2'b10) ? w_slice_cout : 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_serial_alu : randomized and directed checks of serial_alu     |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_serial_alu;

  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int NS    = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_alu_if #(.WIDTH(WIDTH)) bus ();

  serial_alu #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        v;
    logic        c;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] r;
    logic        z;
    logic        v;
    logic        c;
  } vec_t;

  // Reference: plain signed/unsigned arithmetic on whole operands.
  function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mop);
    res_t   o;
    longint sa, sb, sr;
    longint ua, ub;
    o  = '0;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = longint'({32'd0, ma});
    ub = longint'({32'd0, mb});
    case (mop)
      3'b000: o.r = ma & mb;
      3'b001: o.r = ma | mb;
      3'b100: o.r = ma & ~mb;
      3'b101: o.r = ma | ~mb;
      3'b010: begin
        sr  = sa + sb;
        o.r = ma + mb;
        o.c = ((ua + ub) > 64'hFFFF_FFFF);
        o.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'b110: begin
        sr  = sa - sb;
        o.r = ma - mb;
        o.c = (ma >= mb);
        o.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      default: o.r = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] xop,
                        output res_t got, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    bus.a = xa; bus.b = xb; bus.op = xop; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    got = {bus.result, bus.zero, bus.overflow, bus.cout};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.overflow, bus.cout} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h z=%b v=%b c=%b, expected rdy=1 vld=0 res=0 flags=0",
               bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.overflow, bus.cout);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    vec_t v[9];
    res_t got;
    int   lat;
    v[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    v[1] = '{32'h0000_0005, 32'h0000_0005, 3'b110, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    v[2] = '{32'h0000_0000, 32'h0000_0001, 3'b110, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    v[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    v[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    v[5] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    v[6] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0};
    v[7] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0};
    v[8] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101, 32'hF0FF_F0FF, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].a, v[i].b, v[i].op, got, lat);
      n_cmp++;
      if (got !== {v[i].r, v[i].z, v[i].v, v[i].c}) begin
        n_err++;
        $display("FAIL directed_%0d: got res=%h z=%b v=%b c=%b, expected res=%h z=%b v=%b c=%b",
                 i, got.r, got.z, got.v, got.c, v[i].r, v[i].z, v[i].v, v[i].c);
      end
      n_cmp++;
      if (lat !== NS) begin
        n_err++;
        $display("FAIL directed_latency_%0d: got %0d cycles, expected %0d", i, lat, NS);
      end
    end
  endtask

  task automatic test_random;
    res_t got, exp;
    int   lat;
    logic [31:0] xa, xb;
    logic [2:0]  xop;
    for (int i = 0; i < 30; i++) begin
      xa  = $urandom;
      xb  = (i % 5 == 0) ? xa : $urandom;
      if (i % 7 == 3) xa = {1'b0, 31'h7FFF_FFFF} ^ {31'd0, xa[0]};
      xop = 3'($urandom_range(0, 7));
      exp = model(xa, xb, xop);
      run_op(xa, xb, xop, got, lat);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random_%0d op=%b a=%h b=%h: got res=%h z=%b v=%b c=%b, expected res=%h z=%b v=%b c=%b",
                 i, xop, xa, xb, got.r, got.z, got.v, got.c, exp.r, exp.z, exp.v, exp.c);
      end
      n_cmp++;
      if (lat !== NS) begin
        n_err++;
        $display("FAIL random_latency_%0d: got %0d cycles, expected %0d", i, lat, NS);
      end
    end
  endtask

  task automatic test_backpressure;
    res_t got;
    int   lat;
    bus.a = 32'h7FFF_FFFF; bus.b = 32'h0000_0001; bus.op = 3'b010; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        bus.a = 32'd0; bus.b = 32'd0; bus.op = 3'b000; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.overflow, bus.cout} !== {2'b10, 32'h8000_0000, 3'b010}) begin
        n_err++;
        $display("FAIL backpressure_hold_%0d: got vld=%b rdy=%b res=%h z=%b v=%b c=%b, expected vld=1 rdy=0 res=80000000 z=0 v=1 c=0",
                 k, bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.overflow, bus.cout);
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b, expected vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    run_op(32'd9, 32'd4, 3'b110, got, lat);
    n_cmp++;
    if (got !== {32'd5, 3'b001} || lat !== NS) begin
      n_err++;
      $display("FAIL backpressure_next_op: got res=%h flags=%b lat=%0d, expected res=5 flags=001 lat=%0d",
               got.r, {got.z, got.v, got.c}, lat, NS);
    end
  endtask

  task automatic test_back_to_back;
    res_t exp_q[$];
    res_t e;
    int   last_acc;
    logic will_acc;
    last_acc = -1;
    bus.out_ready = 1'b1;
    bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom_range(0, 7));
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      will_acc = bus.in_ready && bus.in_valid;
      if (will_acc) exp_q.push_back(model(bus.a, bus.b, bus.op));
      if (bus.out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected_result: got res=%h, expected no result", bus.result);
        end else begin
          e = exp_q.pop_front();
          if ({bus.result, bus.zero, bus.overflow, bus.cout} !== e) begin
            n_err++;
            $display("FAIL b2b_result: got res=%h flags=%b, expected res=%h flags=%b",
                     bus.result, {bus.zero, bus.overflow, bus.cout}, e.r, {e.z, e.v, e.c});
          end
        end
      end
      @(posedge clk); #1;
      if (will_acc) begin
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc !== NS + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles, expected %0d", cyc - last_acc, NS + 2);
          end
        end
        last_acc = cyc;
        bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom_range(0, 7));
      end
    end
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
      if (bus.out_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.result, bus.zero, bus.overflow, bus.cout} !== e) begin
          n_err++;
          $display("FAIL b2b_drain: got res=%h, expected res=%h", bus.result, e.r);
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_pending: got %0d results outstanding, expected 0", exp_q.size());
    end
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    res_t got;
    int   lat;
    int   seen;
    run_op(32'h1234, 32'h0, 3'b010, got, lat);
    n_cmp++;
    if (got.r !== 32'h1234) begin
      n_err++;
      $display("FAIL midreset_setup: got res=%h, expected 00001234", got.r);
    end
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h1111_1111; bus.op = 3'b010; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.result} !== {2'b01, 32'd0}) begin
      n_err++;
      $display("FAIL midreset_clear: got vld=%b rdy=%b res=%h, expected vld=0 rdy=1 res=0",
               bus.out_valid, bus.in_ready, bus.result);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_no_output: got %0d valid cycles rdy=%b, expected 0 valid cycles rdy=1", seen, bus.in_ready);
    end
    run_op(32'd2, 32'd3, 3'b010, got, lat);
    n_cmp++;
    if (got !== {32'd5, 3'b000} || lat !== NS) begin
      n_err++;
      $display("FAIL midreset_add: got res=%h flags=%b lat=%0d, expected res=5 flags=000 lat=%0d",
               got.r, {got.z, got.v, got.c}, lat, NS);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
